// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convolution window sequencer.
package conv_seq_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DIM_W_DEF      = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FETCH,
        ST_STORE,
        ST_FINISH
    } seq_state_e;

endpackage

// File: rtl/conv_seq_index_counter.sv
// Nested loop counters for filter, window origin (y0, x0) and kernel tap (ky, kx).
// Origins step by the stride directly, so no division is ever needed.
module conv_seq_index_counter
    import conv_seq_pkg::*;
#(
    parameter int DIM_W = DIM_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic [DIM_W-1:0] img_w_i,
    input  logic [DIM_W-1:0] img_h_i,
    input  logic [3:0]       kernel_i,
    input  logic [1:0]       stride_i,
    input  logic [DIM_W-1:0] num_filters_i,
    output logic [DIM_W-1:0] f_o,
    output logic [DIM_W-1:0] y0_o,
    output logic [DIM_W-1:0] x0_o,
    output logic [3:0]       ky_o,
    output logic [3:0]       kx_o,
    output logic             window_last_o,
    output logic             all_done_o
);

    localparam int EXT_W = DIM_W + 2;

    logic [DIM_W-1:0] f_q, f_d, y0_q, y0_d, x0_q, x0_d;
    logic [3:0]       ky_q, ky_d, kx_q, kx_d;
    logic             done_q, done_d;
    logic             kx_wrap, ky_wrap, x_wrap, y_wrap, f_wrap;

    // A row/column wraps once the next origin would push the window past the image edge.
    assign kx_wrap = (kx_q == kernel_i - 4'd1);
    assign ky_wrap = (ky_q == kernel_i - 4'd1);
    assign x_wrap  = (EXT_W'(x0_q) + EXT_W'(stride_i) + EXT_W'(kernel_i)) > EXT_W'(img_w_i);
    assign y_wrap  = (EXT_W'(y0_q) + EXT_W'(stride_i) + EXT_W'(kernel_i)) > EXT_W'(img_h_i);
    assign f_wrap  = (f_q == num_filters_i - DIM_W'(1));

    always_comb begin
        f_d    = f_q;
        y0_d   = y0_q;
        x0_d   = x0_q;
        ky_d   = ky_q;
        kx_d   = kx_q;
        done_d = done_q;
        if (clear_i) begin
            f_d    = '0;
            y0_d   = '0;
            x0_d   = '0;
            ky_d   = '0;
            kx_d   = '0;
            done_d = 1'b0;
        end else if (advance_i) begin
            kx_d = kx_wrap ? 4'd0 : kx_q + 4'd1;
            if (kx_wrap) begin
                ky_d = ky_wrap ? 4'd0 : ky_q + 4'd1;
                if (ky_wrap) begin
                    x0_d = x_wrap ? '0 : x0_q + DIM_W'(stride_i);
                    if (x_wrap) begin
                        y0_d = y_wrap ? '0 : y0_q + DIM_W'(stride_i);
                        if (y_wrap) begin
                            f_d = f_wrap ? '0 : f_q + DIM_W'(1);
                            if (f_wrap) begin
                                done_d = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            f_q    <= '0;
            y0_q   <= '0;
            x0_q   <= '0;
            ky_q   <= '0;
            kx_q   <= '0;
            done_q <= 1'b0;
        end else begin
            f_q    <= f_d;
            y0_q   <= y0_d;
            x0_q   <= x0_d;
            ky_q   <= ky_d;
            kx_q   <= kx_d;
            done_q <= done_d;
        end
    end

    assign f_o           = f_q;
    assign y0_o          = y0_q;
    assign x0_o          = x0_q;
    assign ky_o          = ky_q;
    assign kx_o          = kx_q;
    assign window_last_o = kx_wrap && ky_wrap;
    assign all_done_o    = done_q;

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks every convolution window of a layer, issuing one fetch per kernel tap
// (input + weight address) and one store per window.
module conv_window_sequencer
    import conv_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DIM_W  = DIM_W_DEF
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_img_w,
    input  logic [DIM_W-1:0]  cfg_img_h,
    input  logic [3:0]        cfg_kernel,
    input  logic [1:0]        cfg_stride,
    input  logic [DIM_W-1:0]  cfg_num_filters,
    input  logic [ADDR_W-1:0] cfg_in_base,
    input  logic [ADDR_W-1:0] cfg_wt_base,
    input  logic [ADDR_W-1:0] cfg_out_base,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              fetch_valid,
    input  logic              fetch_ready,
    output logic [ADDR_W-1:0] fetch_addr_in,
    output logic [ADDR_W-1:0] fetch_addr_wt,
    output logic              fetch_last,
    output logic              store_valid,
    input  logic              store_ready,
    output logic [ADDR_W-1:0] store_addr
);

    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(BYTES_PER_WORD);

    seq_state_e        state_q;
    logic              busy_q, done_q, error_q, fetch_valid_q, store_valid_q;
    logic [DIM_W-1:0]  img_w_q, img_h_q, num_filters_q;
    logic [3:0]        kernel_q;
    logic [1:0]        stride_q;
    logic [ADDR_W-1:0] in_base_q, wt_base_q, out_base_q, n_q;

    logic [DIM_W-1:0]  idx_f, idx_y0, idx_x0;
    logic [3:0]        idx_ky, idx_kx;
    logic              window_last, all_done, cnt_clear, cnt_advance, cfg_fault;
    logic [ADDR_W-1:0] in_word, wt_word, kk;

    // Fault is judged on the raw inputs so the done pulse lands in the CHECK cycle.
    assign cfg_fault = (cfg_kernel == 4'd0) || (cfg_stride == 2'd0) ||
                       (cfg_num_filters == '0) ||
                       (DIM_W'(cfg_kernel) > cfg_img_w) || (DIM_W'(cfg_kernel) > cfg_img_h);

    assign cnt_clear   = (state_q == ST_IDLE) && start;
    assign cnt_advance = (state_q == ST_FETCH) && fetch_valid_q && fetch_ready;

    conv_seq_index_counter #(.DIM_W(DIM_W)) u_index (
        .clk_i         (ACLK),
        .rst_ni        (ARESETN),
        .clear_i       (cnt_clear),
        .advance_i     (cnt_advance),
        .img_w_i       (img_w_q),
        .img_h_i       (img_h_q),
        .kernel_i      (kernel_q),
        .stride_i      (stride_q),
        .num_filters_i (num_filters_q),
        .f_o           (idx_f),
        .y0_o          (idx_y0),
        .x0_o          (idx_x0),
        .ky_o          (idx_ky),
        .kx_o          (idx_kx),
        .window_last_o (window_last),
        .all_done_o    (all_done)
    );

    assign kk      = ADDR_W'(kernel_q);
    assign in_word = (ADDR_W'(idx_y0) + ADDR_W'(idx_ky)) * ADDR_W'(img_w_q)
                   + ADDR_W'(idx_x0) + ADDR_W'(idx_kx);
    assign wt_word = ADDR_W'(idx_f) * kk * kk + ADDR_W'(idx_ky) * kk + ADDR_W'(idx_kx);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            fetch_valid_q <= 1'b0;
            store_valid_q <= 1'b0;
            img_w_q       <= '0;
            img_h_q       <= '0;
            num_filters_q <= '0;
            kernel_q      <= '0;
            stride_q      <= '0;
            in_base_q     <= '0;
            wt_base_q     <= '0;
            out_base_q    <= '0;
            n_q           <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        img_w_q       <= cfg_img_w;
                        img_h_q       <= cfg_img_h;
                        num_filters_q <= cfg_num_filters;
                        kernel_q      <= cfg_kernel;
                        stride_q      <= cfg_stride;
                        in_base_q     <= cfg_in_base;
                        wt_base_q     <= cfg_wt_base;
                        out_base_q    <= cfg_out_base;
                        n_q           <= '0;
                        error_q       <= cfg_fault;
                        done_q        <= cfg_fault;
                        busy_q        <= 1'b1;
                        state_q       <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (error_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        fetch_valid_q <= 1'b1;
                        state_q       <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (fetch_ready && window_last) begin
                        fetch_valid_q <= 1'b0;
                        store_valid_q <= 1'b1;
                        state_q       <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    if (store_ready) begin
                        store_valid_q <= 1'b0;
                        n_q           <= n_q + 1'b1;
                        if (all_done) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_FINISH;
                        end else begin
                            fetch_valid_q <= 1'b1;
                            state_q       <= ST_FETCH;
                        end
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign fetch_valid   = fetch_valid_q;
    assign fetch_last    = fetch_valid_q && window_last;
    assign fetch_addr_in = in_base_q + in_word * WORD_BYTES;
    assign fetch_addr_wt = wt_base_q + wt_word * WORD_BYTES;
    assign store_valid   = store_valid_q;
    assign store_addr    = out_base_q + n_q * WORD_BYTES;

endmodule

// File: doc/conv_window_sequencer.md
CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of all base and request addresses.
REQ-002 SHALL have parameter DIM_W, default 8, width of image-dimension and filter-count fields.
REQ-003 SHALL have port ACLK, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port ARESETN, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that launches a layer run.
REQ-006 SHALL have ports cfg_img_w and cfg_img_h, inputs, DIM_W bits each: input image width and height in words.
REQ-007 SHALL have port cfg_kernel, input, 4 bits: square kernel size K.
REQ-008 SHALL have port cfg_stride, input, 2 bits: window stride S.
REQ-009 SHALL have port cfg_num_filters, input, DIM_W bits: filter count F.
REQ-010 SHALL have ports cfg_in_base, cfg_wt_base and cfg_out_base, inputs, ADDR_W bits each: byte base addresses.
REQ-011 SHALL have ports busy, done and error, outputs, 1 bit each: run active; one-cycle completion pulse; config fault.
REQ-012 SHALL have ports fetch_valid (output, 1), fetch_ready (input, 1), fetch_addr_in (output, ADDR_W), fetch_addr_wt (output, ADDR_W) and fetch_last (output, 1, last tap of the window).
REQ-013 SHALL have ports store_valid (output, 1), store_ready (input, 1) and store_addr (output, ADDR_W).

Function
REQ-014 SHALL implement states IDLE, CHECK, FETCH, STORE and FINISH.
REQ-015 SHALL register all cfg_* inputs on a start accepted in IDLE; cfg changes while busy SHALL be ignored.
REQ-016 SHALL ignore start in any state other than IDLE.
REQ-017 SHALL go IDLE->CHECK on start, so busy=1 from cycle T+1, where T is the start cycle.
REQ-018 SHALL, in CHECK, fault when K=0, S=0, F=0, K>img_w or K>img_h; on a fault it SHALL set error, pulse done, go to IDLE and issue no transfers.
REQ-019 SHALL otherwise go CHECK->FETCH, with the first fetch_valid in cycle T+2.
REQ-020 SHALL iterate loops outermost to innermost: f in 0..F-1, oy, ox, ky in 0..K-1, kx in 0..K-1.
REQ-021 SHALL step the window origin as x0=ox*S while x0+K<=img_w, and y0=oy*S while y0+K<=img_h; no divider is needed.
REQ-022 SHALL drive fetch_addr_in = in_base + 4*((y0+ky)*img_w + x0+kx).
REQ-023 SHALL drive fetch_addr_wt = wt_base + 4*(f*K*K + ky*K + kx).
REQ-024 SHALL compute all address arithmetic modulo 2^ADDR_W.
REQ-025 SHALL, on both channels, hold valid and payload stable until ready; a transfer occurs when valid and ready are both 1; valid SHALL NOT depend combinationally on ready.
REQ-026 SHALL assert fetch_last with the kx=K-1, ky=K-1 tap; acceptance of that tap SHALL go FETCH->STORE.
REQ-027 SHALL drive store_addr = out_base + 4*n, where n counts completed stores from 0 across the whole run.
REQ-028 SHALL, on store acceptance, go STORE->FETCH for the next window, or STORE->FINISH after the last window of the last filter.
REQ-029 SHALL, in FINISH, assert done for exactly one cycle with busy=0, then go to IDLE.
REQ-030 SHALL allow back-to-back fetches: with fetch_ready held 1, one tap is accepted per cycle.
REQ-031 SHALL hold error until the next accepted start, which clears it.

Reset
REQ-032 SHALL, while ARESETN=0 at any time including mid-run, force state IDLE, all counters 0, and busy=done=error=fetch_valid=fetch_last=store_valid=0, with all address outputs 0.
REQ-033 SHALL require a fresh start after reset release; no run resumes.

Structure
REQ-034 SHALL take the state enum, BYTES_PER_WORD=4 and default ADDR_W/DIM_W from shared package conv_seq_pkg.
REQ-035 SHALL place the five nested loop counters, with their wrap and carry logic, in one sub-module conv_seq_index_counter, which has an advance input and an all_done output.

Verification
REQ-036 SHALL cover nominal run: 3x3 image, K=2, S=1, F=1, bases 0x1000/0x2000/0x3000, ready held 1 -> 16 fetches, 4 stores; first window in-addrs 0x1000,0x1004,0x100C,0x1010; stores 0x3000..0x300C; one done pulse.
REQ-037 SHALL cover stride: 5x5 image, K=3, S=2, F=2 -> 8 windows, 72 fetches; origins (0,0),(2,0),(0,2),(2,2); second-filter first wt-addr = wt_base+0x24.
REQ-038 SHALL cover backpressure: random fetch_ready/store_ready, about 50% -> payload stable while stalled and the same address sequence as REQ-036.
REQ-039 SHALL cover faults: K=0, or K=4 with 3x3 image -> error=1, done pulse at T+1, no fetch_valid; the next valid start clears error.
REQ-040 SHALL cover reset and re-start: ARESETN low after the 5th fetch -> all outputs 0 at once; restart reproduces REQ-036 exactly. A start pulsed while busy SHALL be ignored and the address trace unchanged.
